mmu_loader: RTL and testbench

Upstream stage of the 2x2 matrix unit: it accepts the host's byte stream of four weights followed by four inputs and holds them in operand registers. Once all operands are captured it runs the feeder by driving `en` and a 0..5 `mmu_cycles` count, then re-arms for the next load. Its outputs connect directly to the feeder's `weight_*`, `input_*`, `en` and `mmu_cycles` inputs.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/mmu_cycle_counter.sv | 27 ++
 rtl/mmu_loader.sv | 121 ++++++++++++
 tb/tb_mmu_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and types for the matrix-unit front end.
package tpu_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] MMU_LAST_CYCLE = 3'd5;
  localparam int         LOAD_BYTES     = 8;
  localparam int         INPUT_BASE_IDX = 4;

  localparam logic [2:0] LAST_IDX  = 3'(LOAD_BYTES - 1);
  localparam logic [2:0] INPUT_IDX = 3'(INPUT_BASE_IDX);

endpackage

// File: rtl/mmu_cycle_counter.sv
// Feeder step counter: walks 0..MMU_LAST_CYCLE while running and flags the
// final step so the loader can leave RUN.
module mmu_cycle_counter
  import tpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       run_i,
  input  logic       flush_i,
  output logic [2:0] cnt_o,
  output logic       tc_o
);

  logic [2:0] cnt_q;

  assign tc_o  = run_i && (cnt_q == MMU_LAST_CYCLE);
  assign cnt_o = cnt_q;

  // Count while running; any start, flush or wrap returns to step 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt_q <= 3'd0;
    else if (flush_i || start_i || tc_o) cnt_q <= 3'd0;
    else if (run_i)                    cnt_q <= cnt_q + 3'd1;
  end

endmodule

// File: rtl/mmu_loader.sv
// Operand loader for the 2x2 matrix unit: collects four weight bytes and
// four input bytes from the host, then runs the feeder for six steps.
// Optional build macro: MMU_LOADER_WEIGHT_REUSE_EN (4-byte loads that keep
// the previously captured weights when reuse_w is set).
module mmu_loader
  import tpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       reuse_w,
  input  logic       flush,
  output logic       load_ready,
  output logic [7:0] weight_0,
  output logic [7:0] weight_1,
  output logic [7:0] weight_2,
  output logic [7:0] weight_3,
  output logic [7:0] input_0,
  output logic [7:0] input_1,
  output logic [7:0] input_2,
  output logic [7:0] input_3,
  output logic       en,
  output logic [2:0] mmu_cycles,
  output logic       busy,
  output logic       done
);

  state_e          state_q, state_d;
  logic [2:0]      idx_q;
  logic            w_loaded_q;
  logic [3:0][7:0] weight_q;
  logic [3:0][7:0] input_q;
  logic            done_q;
  logic            accept, last_byte, tc, reuse_hit;

  // A byte presented alongside flush is dropped.
  assign accept    = load_valid && load_ready && !flush;
  assign last_byte = accept && (idx_q == LAST_IDX);

`ifdef MMU_LOADER_WEIGHT_REUSE_EN
  assign reuse_hit = accept && (idx_q == 3'd0) && reuse_w && w_loaded_q;
`else
  logic unused_reuse;
  assign reuse_hit    = 1'b0;
  assign unused_reuse = reuse_w ^ w_loaded_q;
`endif

  mmu_cycle_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (last_byte),
    .run_i   (state_q == ST_RUN),
    .flush_i (flush),
    .cnt_o   (mmu_cycles),
    .tc_o    (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // Next state: flush wins, otherwise LOAD->RUN on the last byte, RUN->LOAD on terminal count.
  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_LOAD;
    else begin
      case (state_q)
        ST_LOAD: if (last_byte) state_d = ST_RUN;
        ST_RUN:  if (tc)        state_d = ST_LOAD;
        default:                state_d = ST_LOAD;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    load_ready = (state_q == ST_LOAD);
    en         = (state_q == ST_RUN);
    busy       = (state_q == ST_RUN);
  end

  // Byte index and operand capture; registers only move on accepted bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 3'd0;
      w_loaded_q <= 1'b0;
      weight_q   <= '0;
      input_q    <= '0;
    end else if (flush) begin
      idx_q <= 3'd0;
    end else if (reuse_hit) begin
      input_q[0] <= load_data;
      idx_q      <= INPUT_IDX + 3'd1;
    end else if (accept) begin
      if (idx_q < INPUT_IDX) weight_q[idx_q[1:0]] <= load_data;
      else                   input_q[idx_q[1:0]]  <= load_data;
      if (idx_q == INPUT_IDX - 3'd1) w_loaded_q <= 1'b1;
      idx_q <= last_byte ? 3'd0 : idx_q + 3'd1;
    end
  end

  // One-cycle done on a natural end of run; a flush suppresses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= tc && !flush;
  end

  assign done     = done_q;
  assign weight_0 = weight_q[0];
  assign weight_1 = weight_q[1];
  assign weight_2 = weight_q[2];
  assign weight_3 = weight_q[3];
  assign input_0  = input_q[0];
  assign input_1  = input_q[1];
  assign input_2  = input_q[2];
  assign input_3  = input_q[3];

endmodule

// File: tb/tb_mmu_loader.sv
// Scoreboard bench for mmu_loader: a transaction-level model predicts
// operand snapshots and per-cycle handshake state; a monitor compares.
module tb_mmu_loader;

`ifdef MMU_LOADER_WEIGHT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       load_valid = 1'b0, reuse_w = 1'b0, flush = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, en, busy, done;
  logic [7:0] weight_0, weight_1, weight_2, weight_3;
  logic [7:0] input_0, input_1, input_2, input_3;
  logic [2:0] mmu_cycles;
  logic [63:0] dut_ops;

  mmu_loader dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .reuse_w(reuse_w), .flush(flush), .load_ready(load_ready),
    .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
    .input_0(input_0), .input_1(input_1), .input_2(input_2), .input_3(input_3),
    .en(en), .mmu_cycles(mmu_cycles), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign dut_ops = {input_3, input_2, input_1, input_0, weight_3, weight_2, weight_1, weight_0};

  int n_chk = 0, n_fail = 0;

  // Model: 8 operand slots (0..3 weights, 4..7 inputs), next slot, run step (-1 idle).
  logic [7:0]  m_op [8];
  int          m_idx = 0, m_run = -1;
  bit          m_wl = 0, m_done = 0;
  logic [63:0] exp_q [$];

  function automatic logic [63:0] model_ops();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = m_op[i];
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_op[i] = 8'h00;
    m_idx = 0; m_run = -1; m_wl = 0; m_done = 0;
  endtask

  task automatic model_byte(logic [7:0] d);
    if (REUSE && m_idx == 0 && reuse_w && m_wl) begin
      m_op[4] = d;
      m_idx   = 5;
    end else begin
      m_op[m_idx] = d;
      if (m_idx == 3) m_wl = 1;
      if (m_idx == 7) begin
        m_idx = 0;
        m_run = 0;
        exp_q.push_back(model_ops());
      end else m_idx++;
    end
  endtask

  // Reference model, advanced on every clock edge and on asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (flush) begin
        m_run = -1; m_idx = 0; m_done = 0;
      end else if (m_run >= 0) begin
        m_done = (m_run == 5);
        m_run  = (m_run == 5) ? -1 : m_run + 1;
      end else begin
        m_done = 0;
        if (load_valid) model_byte(load_data);
      end
    end
  end

  // Monitor: per-cycle handshake checks plus scoreboard pop at each run start.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("load_ready", 64'(load_ready), 64'(m_run < 0));
      chk("en",         64'(en),         64'(m_run >= 0));
      chk("busy",       64'(busy),       64'(m_run >= 0));
      chk("mmu_cycles", 64'(mmu_cycles), 64'((m_run < 0) ? 0 : m_run));
      chk("done",       64'(done),       64'(m_done));
      chk("operands",   dut_ops,         model_ops());
      if (en && mmu_cycles == 3'd0) begin
        if (exp_q.size() == 0) chk("run_without_txn", 64'(1), 64'(0));
        else                   chk("run_operands", dut_ops, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    load_valid = 0; flush = 0;
    while (!load_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", 64'(load_ready), 64'(1));
  endtask

  // Streams consecutive bytes while the loader accepts; returns count accepted.
  task automatic send_until_run(logic [7:0] start, bit rw, output int nb);
    wait_ready();
    reuse_w = rw;
    nb = 0;
    while (nb < 10) begin
      @(negedge clk);
      if (!load_ready) break;
      load_valid = 1;
      load_data  = start + 8'(nb);
      nb++;
    end
    load_valid = 0;
    reuse_w    = 0;
  endtask

  task automatic wait_cycle(logic [2:0] c);
    int k = 0;
    while (mmu_cycles != c && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cycle_wait", 64'(mmu_cycles), 64'(c));
  endtask

  initial begin
    int nb;
    #1;
    chk("reset_ready", 64'(load_ready), 64'(1));
    chk("reset_en",    64'(en),         64'(0));
    chk("reset_ops",   dut_ops,         64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Full load held back-to-back, then bytes offered during RUN are dropped.
    send_until_run(8'd1, 0, nb);
    chk("bytes_full", 64'(nb), 64'(8));
    load_valid = 1; load_data = 8'hFF;
    repeat (4) @(negedge clk);
    load_valid = 0;
    wait_ready();
    chk("ops_after_run", dut_ops, 64'h0807060504030201);

    // Flush after three bytes restarts the load at index 0.
    repeat (3) begin
      @(negedge clk);
      load_valid = 1; load_data = 8'hA5;
    end
    @(negedge clk); load_valid = 0; flush = 1;
    @(negedge clk); flush = 0;
    send_until_run(8'h10, 0, nb);
    chk("bytes_after_flush", 64'(nb), 64'(8));
    wait_ready();
    chk("ops_after_flush", dut_ops, 64'h1716151413121110);

    // Flush mid-run with a byte offered in the same cycle.
    send_until_run(8'h20, 0, nb);
    wait_cycle(3'd3);
    flush = 1; load_valid = 1; load_data = 8'hAA;
    @(negedge clk);
    flush = 0; load_valid = 0;
    chk("flush_kills_en", 64'(en), 64'(0));

    // Weight reuse after a full load.
    send_until_run(8'd1, 0, nb);
    send_until_run(8'd9, 1, nb);
    chk("reuse_len", 64'(nb), REUSE ? 64'(4) : 64'(8));
    wait_ready();
    chk("reuse_ops", dut_ops, REUSE ? 64'h0C0B0A0904030201 : 64'h100F0E0D0C0B0A09);

    // Asynchronous reset in the middle of a run.
    send_until_run(8'h30, 0, nb);
    wait_cycle(3'd2);
    #2 rst_n = 0;
    #1;
    chk("arst_ready", 64'(load_ready), 64'(1));
    chk("arst_en",    64'(en),         64'(0));
    chk("arst_busy",  64'(busy),       64'(0));
    chk("arst_cyc",   64'(mmu_cycles), 64'(0));
    chk("arst_done",  64'(done),       64'(0));
    chk("arst_ops",   dut_ops,         64'(0));
    @(negedge clk); #1 rst_n = 1;

    // Reuse request with no weights loaded needs the full sequence.
    send_until_run(8'h40, 1, nb);
    chk("reuse_cold_len", 64'(nb), 64'(8));
    wait_ready();

    // Randomised traffic.
    repeat (400) begin
      @(negedge clk);
      load_valid = ($urandom % 10) < 7;
      load_data  = 8'($urandom);
      flush      = ($urandom % 40) == 0;
      reuse_w    = 1'($urandom);
    end
    wait_ready();
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
